// File: rtl/uart_cmd_pkg.sv
// Shared opcodes, FSM encodings and the command record for the UART command receiver.
package uart_cmd_pkg;

  localparam int MAX_ADDR_BYTES = 4;
  localparam int MAX_DATA_BYTES = 4;

  localparam logic [7:0] OPC_READ  = 8'h00;
  localparam logic [7:0] OPC_WRITE = 8'h01;

  typedef enum logic [1:0] {FR_OPC, FR_ADDR, FR_DATA, FR_HOLD} t_frame_state;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} t_rx_state;

  typedef struct packed {
    logic                        write;
    logic [8*MAX_ADDR_BYTES-1:0] addr;
    logic [8*MAX_DATA_BYTES-1:0] wdata;
  } t_uart_cmd;

endpackage

// File: rtl/uart_rx_8n1.sv
// 8N1 UART byte receiver: input synchroniser, mid-bit sampling and stop-bit check.
module uart_rx_8n1
  import uart_cmd_pkg::*;
#(
  parameter int CLKS_PER_BIT = 87
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       uart_rx,
  output logic       rx_byte_valid,
  output logic [7:0] rx_byte,
  output logic       err_frame,
  output logic       rx_idle
);

  localparam int            CW      = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

  logic [1:0]    sync;
  logic          rx_s;
  t_rx_state     state;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic          brk;

  assign rx_s    = sync[1];
  assign rx_idle = (state == RX_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      sync          <= 2'b11;
      state         <= RX_IDLE;
      cnt           <= '0;
      bit_idx       <= '0;
      shreg         <= '0;
      brk           <= 1'b0;
      rx_byte_valid <= 1'b0;
      rx_byte       <= '0;
      err_frame     <= 1'b0;
    end else begin
      sync          <= {sync[0], uart_rx};
      rx_byte_valid <= 1'b0;
      err_frame     <= 1'b0;
      case (state)
        RX_IDLE: if (!rx_s) begin
          state <= RX_START;
          cnt   <= '0;
        end
        RX_START: if (cnt == HALF_M1) begin
          cnt     <= '0;
          bit_idx <= '0;
          state   <= rx_s ? RX_IDLE : RX_DATA;
        end else cnt <= cnt + 1'b1;
        RX_DATA: if (cnt == FULL_M1) begin
          cnt     <= '0;
          shreg   <= {rx_s, shreg[7:1]};
          bit_idx <= bit_idx + 1'b1;
          if (bit_idx == 3'd7) state <= RX_STOP;
        end else cnt <= cnt + 1'b1;
        RX_STOP: begin
          // brk: stop bit was low, hold here until the line returns high
          if (brk) begin
            if (rx_s) begin
              brk   <= 1'b0;
              state <= RX_IDLE;
            end
          end else if (cnt == FULL_M1) begin
            cnt <= '0;
            if (rx_s) begin
              rx_byte_valid <= 1'b1;
              rx_byte       <= shreg;
              state         <= RX_IDLE;
            end else begin
              err_frame <= 1'b1;
              brk       <= 1'b1;
            end
          end else cnt <= cnt + 1'b1;
        end
        default: state <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/uart_cmd_rx.sv
// UART command framer: opcode/address/data assembly, inter-byte timeout and a one-deep command output register.
module uart_cmd_rx
  import uart_cmd_pkg::*;
#(
  parameter int CLKS_PER_BIT = 87,
  parameter int ADDR_BYTES   = 3,
  parameter int DATA_BYTES   = 1,
  parameter int TIMEOUT_BITS = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    uart_rx,
  output logic                    cmd_valid,
  input  logic                    cmd_ready,
  output logic                    cmd_write,
  output logic [8*ADDR_BYTES-1:0] cmd_addr,
  output logic [8*DATA_BYTES-1:0] cmd_wdata,
  output logic                    rx_byte_valid,
  output logic [7:0]              rx_byte,
  output logic                    err_frame,
  output logic                    err_opcode,
  output logic                    err_timeout,
  output logic                    err_overrun
);

  localparam int AW  = 8 * ADDR_BYTES;
  localparam int DW  = 8 * DATA_BYTES;
  localparam int TMO = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int TW  = $clog2(TMO + 1);

  logic rx_idle;

  uart_rx_8n1 #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk          (clk),
    .rst          (rst),
    .uart_rx      (uart_rx),
    .rx_byte_valid(rx_byte_valid),
    .rx_byte      (rx_byte),
    .err_frame    (err_frame),
    .rx_idle      (rx_idle)
  );

  t_frame_state  state;
  logic          wr_q;
  logic [AW-1:0] addr_sr;
  logic [DW-1:0] data_sr;
  logic [2:0]    bcnt;
  logic [TW-1:0] tmo;
  t_uart_cmd     cmd_q;

  logic [AW+7:0] addr_shift;
  logic [DW+7:0] data_shift;
  t_uart_cmd     cmd_new;
  logic          done;
  logic          tmo_run;
  logic          spare_unused;

  always_comb begin
    addr_shift = {addr_sr, rx_byte};
    data_shift = {data_sr, rx_byte};
    cmd_new    = '0;
    cmd_new.write = wr_q;
    // a read completes on its last address byte, so the address is still in flight
    cmd_new.addr[AW-1:0] = (state == FR_ADDR) ? addr_shift[AW-1:0] : addr_sr;
    if (wr_q) cmd_new.wdata[DW-1:0] = data_shift[DW-1:0];
    done = rx_byte_valid &&
           ((state == FR_ADDR && bcnt == 3'(ADDR_BYTES - 1) && !wr_q) ||
            (state == FR_DATA && bcnt == 3'(DATA_BYTES - 1)));
  end

  assign tmo_run      = (state == FR_ADDR || state == FR_DATA) && rx_idle;
  assign spare_unused = ^{cmd_q, addr_shift, data_shift};

  assign cmd_write = cmd_q.write;
  assign cmd_addr  = cmd_q.addr[AW-1:0];
  assign cmd_wdata = cmd_q.wdata[DW-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= FR_OPC;
      wr_q        <= 1'b0;
      addr_sr     <= '0;
      data_sr     <= '0;
      bcnt        <= '0;
      tmo         <= '0;
      cmd_q       <= '0;
      cmd_valid   <= 1'b0;
      err_opcode  <= 1'b0;
      err_timeout <= 1'b0;
      err_overrun <= 1'b0;
    end else begin
      err_opcode  <= 1'b0;
      err_timeout <= 1'b0;
      err_overrun <= 1'b0;
      if (cmd_valid && cmd_ready) cmd_valid <= 1'b0;

      if (err_frame) begin
        state <= FR_OPC;
        tmo   <= '0;
      end else if (rx_byte_valid) begin
        // the byte_valid cycle itself counts as the first idle cycle
        tmo <= TW'(1);
        case (state)
          FR_OPC: begin
            if (rx_byte == OPC_READ || rx_byte == OPC_WRITE) begin
              wr_q  <= (rx_byte == OPC_WRITE);
              bcnt  <= '0;
              state <= FR_ADDR;
            end else err_opcode <= 1'b1;
          end
          FR_ADDR: begin
            addr_sr <= addr_shift[AW-1:0];
            bcnt    <= bcnt + 1'b1;
            if (bcnt == 3'(ADDR_BYTES - 1)) begin
              bcnt  <= '0;
              state <= wr_q ? FR_DATA : FR_OPC;
            end
          end
          FR_DATA: begin
            data_sr <= data_shift[DW-1:0];
            bcnt    <= bcnt + 1'b1;
            if (bcnt == 3'(DATA_BYTES - 1)) begin
              bcnt  <= '0;
              state <= FR_OPC;
            end
          end
          default: state <= FR_OPC;
        endcase
        if (done) begin
          if (!cmd_valid || cmd_ready) begin
            cmd_q     <= cmd_new;
            cmd_valid <= 1'b1;
          end else err_overrun <= 1'b1;
        end
      end else if (tmo_run) begin
        if (tmo == TW'(TMO - 1)) begin
          err_timeout <= 1'b1;
          state       <= FR_OPC;
          tmo         <= '0;
        end else tmo <= tmo + 1'b1;
      end else if (state == FR_OPC) begin
        tmo <= '0;
      end
    end
  end

endmodule

// File: tb/tb_uart_cmd_rx.sv
// Randomised and directed bench for uart_cmd_rx with a frame-level reference model.
module tb_uart_cmd_rx;

  localparam int CPB = 8;
  localparam int AB  = 3;
  localparam int DB  = 1;
  localparam int TB  = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          uart_rx = 1'b1;
  logic          cmd_ready = 1'b1;
  logic          cmd_valid, cmd_write;
  logic [8*AB-1:0] cmd_addr;
  logic [8*DB-1:0] cmd_wdata;
  logic          rx_byte_valid;
  logic [7:0]    rx_byte;
  logic          err_frame, err_opcode, err_timeout, err_overrun;

  uart_cmd_rx #(.CLKS_PER_BIT(CPB), .ADDR_BYTES(AB), .DATA_BYTES(DB), .TIMEOUT_BITS(TB)) dut (
    .clk(clk), .rst(rst), .uart_rx(uart_rx),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rx_byte_valid(rx_byte_valid), .rx_byte(rx_byte),
    .err_frame(err_frame), .err_opcode(err_opcode),
    .err_timeout(err_timeout), .err_overrun(err_overrun)
  );

  always #5 clk = ~clk;

  logic [46:0] all_out;
  assign all_out = {cmd_valid, cmd_write, cmd_addr, cmd_wdata, rx_byte_valid, rx_byte,
                    err_frame, err_opcode, err_timeout, err_overrun};

  int total = 0;
  int bad   = 0;

  // passive monitor
  int cyc = 0, n_bv = 0, n_frm = 0, n_opc = 0, n_tmo = 0, n_ovr = 0;
  int n_vcyc = 0, n_wide = 0, n_multi = 0, bv_cyc = 0, tmo_cyc = 0;
  logic [3:0]  err_prev = 4'b0;
  logic [32:0] obs_q[$];
  logic [7:0]  byte_q[$];

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (cmd_valid === 1'b1) n_vcyc <= n_vcyc + 1;
    if (cmd_valid === 1'b1 && cmd_ready === 1'b1) obs_q.push_back({cmd_write, cmd_addr, cmd_wdata});
    if (rx_byte_valid === 1'b1) begin
      n_bv   <= n_bv + 1;
      bv_cyc <= cyc;
      byte_q.push_back(rx_byte);
    end
    if (err_frame === 1'b1) n_frm <= n_frm + 1;
    if (err_opcode === 1'b1) n_opc <= n_opc + 1;
    if (err_timeout === 1'b1) begin
      n_tmo   <= n_tmo + 1;
      tmo_cyc <= cyc;
    end
    if (err_overrun === 1'b1) n_ovr <= n_ovr + 1;
    if (({err_frame, err_opcode, err_timeout, err_overrun} & err_prev) != 4'b0) n_wide <= n_wide + 1;
    if ($countones({err_frame, err_opcode, err_timeout, err_overrun}) > 1) n_multi <= n_multi + 1;
    err_prev <= {err_frame, err_opcode, err_timeout, err_overrun};
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    logic [9:0] fr;
    fr = {stop_bit, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      uart_rx = fr[i];
      tick(CPB);
    end
    uart_rx = 1'b1;
  endtask

  task automatic send_frame(input logic wr, input logic [23:0] a, input logic [7:0] d);
    send_byte(wr ? 8'h01 : 8'h00, 1'b1);
    for (int i = 2; i >= 0; i--) begin
      tick($urandom_range(0, 8));
      send_byte(a[8*i +: 8], 1'b1);
    end
    if (wr) begin
      tick($urandom_range(0, 8));
      send_byte(d, 1'b1);
    end
  endtask

  task automatic wait_obs(input int n, input int budget);
    for (int i = 0; i < budget && obs_q.size() < n; i++) tick(1);
  endtask

  task automatic test_reset;
    rst = 1'b1; uart_rx = 1'b1; cmd_ready = 1'b1;
    tick(3);
    total++;
    if (all_out !== 47'd0) begin bad++; $display("FAIL reset_outputs got=%h exp=0", all_out); end
    rst = 1'b0;
    tick(4 * CPB);
    total++;
    if (all_out !== 47'd0) begin bad++; $display("FAIL idle_outputs got=%h exp=0", all_out); end
  endtask

  task automatic test_read;
    int base, v0, e0;
    base = obs_q.size(); v0 = n_vcyc; e0 = n_frm + n_opc + n_tmo + n_ovr;
    send_frame(1'b0, 24'h223344, 8'h00);
    wait_obs(base + 1, 300);
    tick(20);
    total++;
    if (obs_q.size() != base + 1) begin bad++; $display("FAIL read_count got=%0d exp=%0d", obs_q.size() - base, 1); end
    total++;
    if (obs_q[base] !== {1'b0, 24'h223344, 8'h00}) begin bad++; $display("FAIL read_cmd got=%h exp=%h", obs_q[base], {1'b0, 24'h223344, 8'h00}); end
    total++;
    if (n_vcyc - v0 != 1) begin bad++; $display("FAIL read_valid_cycles got=%0d exp=1", n_vcyc - v0); end
    total++;
    if (n_frm + n_opc + n_tmo + n_ovr - e0 != 0) begin bad++; $display("FAIL read_errors got=%0d exp=0", n_frm + n_opc + n_tmo + n_ovr - e0); end
  endtask

  task automatic test_write_backpressure;
    int base, unstable;
    logic [32:0] exp;
    exp = {1'b1, 24'h123456, 8'hA5};
    base = obs_q.size(); unstable = 0;
    cmd_ready = 1'b0;
    send_frame(1'b1, 24'h123456, 8'hA5);
    for (int i = 0; i < 300 && cmd_valid !== 1'b1; i++) tick(1);
    total++;
    if (cmd_valid !== 1'b1) begin bad++; $display("FAIL wr_valid got=%b exp=1", cmd_valid); end
    for (int i = 0; i < 20; i++) begin
      if (cmd_valid !== 1'b1 || {cmd_write, cmd_addr, cmd_wdata} !== exp) unstable++;
      tick(1);
    end
    total++;
    if (unstable != 0) begin bad++; $display("FAIL wr_hold_stable got=%0d exp=0 unstable cycles", unstable); end
    cmd_ready = 1'b1;
    tick(1);
    total++;
    if (cmd_valid !== 1'b0) begin bad++; $display("FAIL wr_drop got=%b exp=0", cmd_valid); end
    total++;
    if (obs_q.size() != base + 1 || obs_q[base] !== exp) begin bad++; $display("FAIL wr_cmd got=%h exp=%h", obs_q[base], exp); end
  endtask

  task automatic test_overrun;
    int base, o0;
    base = obs_q.size(); o0 = n_ovr;
    cmd_ready = 1'b0;
    send_frame(1'b0, 24'h000001, 8'h00);
    tick(4);
    send_frame(1'b0, 24'h000002, 8'h00);
    tick(20);
    total++;
    if (n_ovr - o0 != 1) begin bad++; $display("FAIL ovr_pulses got=%0d exp=1", n_ovr - o0); end
    total++;
    if (cmd_valid !== 1'b1 || cmd_addr !== 24'h000001) begin bad++; $display("FAIL ovr_pending got=%b/%h exp=1/000001", cmd_valid, cmd_addr); end
    cmd_ready = 1'b1;
    tick(20);
    total++;
    if (obs_q.size() != base + 1 || obs_q[base] !== {1'b0, 24'h000001, 8'h00}) begin bad++; $display("FAIL ovr_retire got=%h n=%0d exp=%h n=1", obs_q[base], obs_q.size() - base, {1'b0, 24'h000001, 8'h00}); end
  endtask

  task automatic test_frame_err;
    int base, f0, b0;
    base = obs_q.size(); f0 = n_frm; b0 = n_bv;
    send_byte(8'h00, 1'b0);
    tick(2 * CPB);
    total++;
    if (n_frm - f0 != 1) begin bad++; $display("FAIL frm_pulse got=%0d exp=1", n_frm - f0); end
    total++;
    if (n_bv - b0 != 0) begin bad++; $display("FAIL frm_byte_dropped got=%0d exp=0", n_bv - b0); end
    send_frame(1'b0, 24'hAABBCC, 8'h00);
    wait_obs(base + 1, 300);
    tick(5);
    total++;
    if (obs_q.size() != base + 1 || obs_q[base] !== {1'b0, 24'hAABBCC, 8'h00}) begin bad++; $display("FAIL frm_next_cmd got=%h exp=%h", obs_q[base], {1'b0, 24'hAABBCC, 8'h00}); end
  endtask

  task automatic test_opcode;
    int base, p0;
    base = obs_q.size(); p0 = n_opc;
    send_byte(8'h7F, 1'b1);
    tick(CPB);
    total++;
    if (n_opc - p0 != 1) begin bad++; $display("FAIL opc_pulse got=%0d exp=1", n_opc - p0); end
    send_frame(1'b0, 24'h5A6B7C, 8'h00);
    wait_obs(base + 1, 300);
    tick(5);
    total++;
    if (obs_q.size() != base + 1 || obs_q[base] !== {1'b0, 24'h5A6B7C, 8'h00}) begin bad++; $display("FAIL opc_next_cmd got=%h exp=%h", obs_q[base], {1'b0, 24'h5A6B7C, 8'h00}); end
  endtask

  task automatic test_timeout;
    int base, t0;
    base = obs_q.size(); t0 = n_tmo;
    send_byte(8'h00, 1'b1);
    send_byte(8'h11, 1'b1);
    tick(40 * CPB);
    total++;
    if (n_tmo - t0 != 1) begin bad++; $display("FAIL tmo_pulse got=%0d exp=1", n_tmo - t0); end
    total++;
    if (tmo_cyc - bv_cyc != TB * CPB) begin bad++; $display("FAIL tmo_delay got=%0d exp=%0d", tmo_cyc - bv_cyc, TB * CPB); end
    total++;
    if (obs_q.size() != base) begin bad++; $display("FAIL tmo_no_cmd got=%0d exp=0", obs_q.size() - base); end
    send_frame(1'b0, 24'h010203, 8'h00);
    wait_obs(base + 1, 300);
    tick(5);
    total++;
    if (obs_q.size() != base + 1 || obs_q[base] !== {1'b0, 24'h010203, 8'h00}) begin bad++; $display("FAIL tmo_next_cmd got=%h exp=%h", obs_q[base], {1'b0, 24'h010203, 8'h00}); end
  endtask

  task automatic test_false_start;
    int b0, e0;
    b0 = n_bv; e0 = n_frm + n_opc + n_tmo + n_ovr;
    uart_rx = 1'b0;
    tick(2);
    uart_rx = 1'b1;
    tick(5 * CPB);
    total++;
    if (n_bv - b0 != 0) begin bad++; $display("FAIL glitch_bytes got=%0d exp=0", n_bv - b0); end
    total++;
    if (n_frm + n_opc + n_tmo + n_ovr - e0 != 0) begin bad++; $display("FAIL glitch_errors got=%0d exp=0", n_frm + n_opc + n_tmo + n_ovr - e0); end
  endtask

  task automatic test_reset_mid;
    int base, e0;
    base = obs_q.size(); e0 = n_frm + n_opc + n_tmo + n_ovr;
    send_byte(8'h00, 1'b1);
    send_byte(8'h22, 1'b1);
    uart_rx = 1'b0;
    tick(3 * CPB);
    rst = 1'b1;
    tick(1);
    total++;
    if (all_out !== 47'd0) begin bad++; $display("FAIL rst_mid_outputs got=%h exp=0", all_out); end
    tick(2);
    rst = 1'b0;
    uart_rx = 1'b1;
    tick(12 * CPB);
    total++;
    if (n_frm + n_opc + n_tmo + n_ovr - e0 != 0) begin bad++; $display("FAIL rst_mid_errors got=%0d exp=0", n_frm + n_opc + n_tmo + n_ovr - e0); end
    send_frame(1'b0, 24'h0A0B0C, 8'h00);
    wait_obs(base + 1, 300);
    tick(5);
    total++;
    if (obs_q.size() != base + 1 || obs_q[base] !== {1'b0, 24'h0A0B0C, 8'h00}) begin bad++; $display("FAIL rst_mid_cmd got=%h exp=%h", obs_q[base], {1'b0, 24'h0A0B0C, 8'h00}); end
  endtask

  task automatic test_random;
    logic [32:0] exp_q[$];
    logic [7:0]  exp_b[$];
    int base, bbase, p0, exp_opc;
    logic        wr;
    logic [23:0] a;
    logic [7:0]  d, op;
    base = obs_q.size(); bbase = byte_q.size(); p0 = n_opc; exp_opc = 0;
    cmd_ready = 1'b1;
    for (int f = 0; f < 16; f++) begin
      if ($urandom_range(0, 7) == 0) begin
        op = 8'($urandom_range(2, 255));
        send_byte(op, 1'b1);
        exp_b.push_back(op);
        exp_opc++;
      end else begin
        wr = 1'($urandom_range(0, 1));
        a  = 24'($urandom);
        d  = 8'($urandom);
        send_frame(wr, a, d);
        exp_b.push_back(wr ? 8'h01 : 8'h00);
        exp_b.push_back(a[23:16]); exp_b.push_back(a[15:8]); exp_b.push_back(a[7:0]);
        if (wr) exp_b.push_back(d);
        exp_q.push_back({wr, a, wr ? d : 8'h00});
      end
      tick($urandom_range(0, 8));
    end
    tick(50);
    total++;
    if (obs_q.size() - base != exp_q.size()) begin bad++; $display("FAIL rnd_cmd_count got=%0d exp=%0d", obs_q.size() - base, exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      total++;
      if (obs_q[base + i] !== exp_q[i]) begin bad++; $display("FAIL rnd_cmd[%0d] got=%h exp=%h", i, obs_q[base + i], exp_q[i]); end
    end
    total++;
    if (n_opc - p0 != exp_opc) begin bad++; $display("FAIL rnd_opc got=%0d exp=%0d", n_opc - p0, exp_opc); end
    total++;
    if (byte_q.size() - bbase != exp_b.size()) begin bad++; $display("FAIL rnd_byte_count got=%0d exp=%0d", byte_q.size() - bbase, exp_b.size()); end
    for (int i = 0; i < exp_b.size(); i++) begin
      total++;
      if (byte_q[bbase + i] !== exp_b[i]) begin bad++; $display("FAIL rnd_byte[%0d] got=%h exp=%h", i, byte_q[bbase + i], exp_b[i]); end
    end
  endtask

  initial begin
    test_reset;
    test_read;
    test_write_backpressure;
    test_overrun;
    test_frame_err;
    test_opcode;
    test_timeout;
    test_false_start;
    test_reset_mid;
    test_random;
    total++;
    if (n_wide != 0) begin bad++; $display("FAIL err_pulse_width got=%0d exp=0 wide pulses", n_wide); end
    total++;
    if (n_multi != 0) begin bad++; $display("FAIL err_exclusive got=%0d exp=0 overlaps", n_multi); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
